// File: rtl/demod_symbol_sequencer.sv
// Turns accepted I/Q symbols into dibits, packs four per byte (first symbol in the LSBs) and queues bytes in a small output FIFO.
// Optional invalid-symbol flag and counter are enabled with `define DEMOD_SEQ_ERRCNT_EN.
module demod_symbol_sequencer #(
  parameter int unsigned FRAME_BYTES = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               sym_valid,
  input  logic signed [15:0] I_in,
  input  logic signed [15:0] Q_in,
  output logic               sym_ready,
  output logic [7:0]         data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done
`ifdef DEMOD_SEQ_ERRCNT_EN
  ,
  output logic               sym_err,
  output logic [7:0]         err_count
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] POS = 16'h0001;
  localparam logic [15:0] NEG = 16'h8000;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [1:0]    idx;
  logic [5:0]    acc;
  logic [7:0]    byte_cnt;

  logic [15:0] i_raw, q_raw;
  logic        i_pos, q_pos, sym_ok;
  logic [1:0]  dibit;
  logic        start, accept, push, pop, last_byte;
  logic [7:0]  new_byte, head_n;

  // Symbol decode, handshakes and next FIFO/FSM values
  always_comb begin
    i_raw     = 16'(I_in);
    q_raw     = 16'(Q_in);
    i_pos     = (i_raw == POS);
    q_pos     = (q_raw == POS);
    sym_ok    = (i_pos || i_raw == NEG) && (q_pos || q_raw == NEG);
    dibit     = sym_ok ? {q_pos, i_pos} : 2'b00;
    start     = (state == IDLE) && frame_start;
    accept    = sym_valid && sym_ready;
    push      = accept && (idx == 2'd3);
    pop       = out_valid && out_ready;
    new_byte  = {dibit, acc};
    last_byte = push && (byte_cnt == 8'(FRAME_BYTES - 1));
    count_n   = count + CW'(push) - CW'(pop);
    rd_ptr_n  = rd_ptr + PW'(pop);
    state_n   = state;
    if (start)          state_n = COLLECT;
    else if (last_byte) state_n = IDLE;
    // The pushed byte becomes the head when nothing else remains ahead of it
    head_n = data_out;
    if (count_n != '0)
      head_n = ((count - CW'(pop)) == '0) ? new_byte : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      acc        <= '0;
      byte_cnt   <= '0;
      sym_ready  <= 1'b0;
      out_valid  <= 1'b0;
      data_out   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef DEMOD_SEQ_ERRCNT_EN
      sym_err    <= 1'b0;
      err_count  <= 8'h00;
`endif
    end else begin
      state      <= state_n;
      count      <= count_n;
      rd_ptr     <= rd_ptr_n;
      data_out   <= head_n;
      out_valid  <= (count_n != '0);
      sym_ready  <= (state_n == COLLECT) && (count_n < CW'(FIFO_DEPTH));
      busy       <= (state_n == COLLECT);
      frame_done <= last_byte;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (start) begin
        idx      <= '0;
        acc      <= '0;
        byte_cnt <= '0;
      end else if (accept) begin
        idx <= idx + 2'd1;
        acc <= {dibit, acc[5:2]};
        if (push) byte_cnt <= byte_cnt + 8'd1;
      end
`ifdef DEMOD_SEQ_ERRCNT_EN
      if (start) begin
        sym_err   <= 1'b0;
        err_count <= 8'h00;
      end else if (accept && !sym_ok) begin
        sym_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_demod_symbol_sequencer.sv
// Bench for demod_symbol_sequencer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_demod_symbol_sequencer;

  localparam int unsigned FB = 80;
  localparam int unsigned D  = 4;
  localparam logic [15:0] POS = 16'h0001;
  localparam logic [15:0] NEG = 16'h8000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_start = 1'b0;
  logic               sym_valid = 1'b0;
  logic signed [15:0] I_in = '0;
  logic signed [15:0] Q_in = '0;
  logic               out_ready = 1'b0;
  logic               sym_ready, out_valid, busy, frame_done;
  logic [7:0]         data_out;
`ifdef DEMOD_SEQ_ERRCNT_EN
  logic               sym_err;
  logic [7:0]         err_count;
`endif

  demod_symbol_sequencer #(.FRAME_BYTES(FB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sym_valid(sym_valid),
    .I_in(I_in), .Q_in(Q_in), .sym_ready(sym_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
`ifdef DEMOD_SEQ_ERRCNT_EN
    , .sym_err(sym_err), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_collect;
  int         m_syms[$];
  int         m_bytes;
  logic [7:0] m_q[$];
  bit         m_done;
  bit         m_err;
  int         m_errcnt;
  logic [7:0] popped[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_valid_sym(input logic [15:0] i, input logic [15:0] q);
    return (i == POS || i == NEG) && (q == POS || q == NEG);
  endfunction

  function automatic int dibit_of(input logic [15:0] i, input logic [15:0] q);
    if (!is_valid_sym(i, q)) return 0;
    return (q == POS ? 2 : 0) + (i == POS ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_collect = 0; m_syms.delete(); m_bytes = 0; m_q.delete();
    m_done = 0; m_err = 0; m_errcnt = 0;
  endtask

  // Apply one clock edge to the model using the inputs present before the edge
  task automatic model_edge();
    bit rdy, acc, pp;
    int b;
    rdy = m_collect && (m_q.size() < D);
    acc = sym_valid && rdy;
    pp  = (m_q.size() > 0) && out_ready;
    m_done = 0;
    if (pp) void'(m_q.pop_front());
    if (!m_collect && frame_start) begin
      m_collect = 1; m_syms.delete(); m_bytes = 0; m_err = 0; m_errcnt = 0;
    end else if (acc) begin
      m_syms.push_back(dibit_of(16'(I_in), 16'(Q_in)));
      if (!is_valid_sym(16'(I_in), 16'(Q_in))) begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
      if (m_syms.size() == 4) begin
        b = 0;
        for (int k = 0; k < 4; k++) b += m_syms[k] << (2 * k);
        m_q.push_back(8'(b));
        m_syms.delete();
        m_bytes++;
        if (m_bytes == FB) begin
          m_collect = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("sym_ready", 32'(sym_ready), 32'(m_collect && (m_q.size() < D)));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("busy", 32'(busy), 32'(m_collect));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    if (m_q.size() > 0) chk("data_out", 32'(data_out), 32'(m_q[0]));
`ifdef DEMOD_SEQ_ERRCNT_EN
    chk("sym_err", 32'(sym_err), 32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
    if (out_valid && out_ready) popped.push_back(data_out);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; sym_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_sym_ready", 32'(sym_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef DEMOD_SEQ_ERRCNT_EN
    chk("rst_sym_err", 32'(sym_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    bit got = 0;
    bit r;
    sym_valid = 1'b1; I_in = i; Q_in = q;
    for (int n = 0; n < 64 && !got; n++) begin
      r = m_collect && (m_q.size() < D);
      cycle();
      got = r;
    end
    chk("send_timeout", 32'(got), 32'd1);
    sym_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  logic [7:0] first;

  initial begin
    model_reset();
    do_reset();

    // Basic byte assembly order
    pulse_start();
    out_ready = 1'b1;
    popped.delete();
    send(NEG, NEG); send(POS, NEG); send(NEG, POS); send(POS, POS);
    repeat (3) cycle();
    chk("e4_count", 32'(popped.size()), 32'd1);
    first = (popped.size() > 0) ? popped[0] : 8'hxx;
    chk("e4_value", 32'(first), 32'hE4);

    // frame_start mid-frame after half a byte must not disturb assembly
    send(POS, POS); send(POS, POS);
    pulse_start();
    send(POS, POS); send(POS, POS);
    repeat (2) cycle();

    // Fill FIFO with consumer stalled, then hold a symbol against the full FIFO
    out_ready = 1'b0;
    for (int n = 0; n < 4 * D; n++)
      send(($urandom_range(0, 1) != 0) ? POS : NEG, ($urandom_range(0, 1) != 0) ? POS : NEG);
    sym_valid = 1'b1; I_in = POS; Q_in = NEG;
    repeat (3) cycle();
    chk("full_sym_ready", 32'(sym_ready), 32'd0);
    sym_valid = 1'b0;
    out_ready = 1'b1;
    repeat (D + 2) cycle();
    chk("drain_sym_ready", 32'(sym_ready), 32'd1);

    // Invalid symbol maps to 00
    send(16'h0005, NEG);
`ifdef DEMOD_SEQ_ERRCNT_EN
    chk("inv_sym_err", 32'(sym_err), 32'd1);
    chk("inv_err_count", 32'(err_count), 32'd1);
`endif

    // Run the frame to completion with all-ones symbols
    for (int n = 0; n < 4 * FB && m_collect; n++) send(POS, POS);
    repeat (4) cycle();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sym_ready", 32'(sym_ready), 32'd0);

    // Error counter saturation
    pulse_start();
    for (int n = 0; n < 300; n++) send(16'h0005, NEG);
`ifdef DEMOD_SEQ_ERRCNT_EN
    chk("sat_err_count", 32'(err_count), 32'd255);
`endif

    // Reset mid-byte discards the partial byte
    do_reset();
    pulse_start();
    send(POS, POS); send(POS, POS);
    do_reset();
    popped.delete();
    pulse_start();
    send(NEG, NEG); send(POS, NEG); send(NEG, POS); send(POS, POS);
    repeat (3) cycle();
    first = (popped.size() > 0) ? popped[0] : 8'hxx;
    chk("post_reset_byte", 32'(first), 32'hE4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int ri, rq;
      frame_start = ($urandom_range(0, 19) == 0);
      sym_valid   = ($urandom_range(0, 9) < 7);
      ri = $urandom_range(0, 9);
      rq = $urandom_range(0, 9);
      I_in = (ri < 4) ? POS : (ri < 8) ? NEG : 16'($urandom);
      Q_in = (rq < 4) ? POS : (rq < 8) ? NEG : 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
